// File: rtl/mem_wb.sv
// ---------------------------------------------------------------------------
// mem_wb -- memory / write-back pipeline stage
//
// Accepts results from the execute stage through a valid/ready handshake.
// Non-memory results are written back one cycle later, one per cycle.
// Loads and stores run a single data-bus transaction and stall execute
// (o_ready low) until the bus acknowledges; loads then write back.
// A word access to an odd address raises a one-cycle fault instead.
//
// Ports
//   i_clk, i_rst          clock (rising edge), async active-low reset
//   i_submit / o_ready    execute result valid / stage can accept
//   i_data, i_addr        ALU result or store data, byte address
//   i_reg_ie              one-hot destination register enable
//   i_mem_access/_we/_width, i_data_page   memory operation controls
//   o_mem_req/_we/_addr/_page/_data/_sel   data-bus request
//   i_mem_ack, i_mem_data                  data-bus acknowledge + read data
//   o_reg_ie, o_reg_data  register-file write enable pulse + data
//   o_fault               misaligned word access pulse
// ---------------------------------------------------------------------------
module mem_wb #(
    parameter int RW    = 16,
    parameter int REGNO = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_submit,
    output logic             o_ready,
    input  logic [RW-1:0]    i_data,
    input  logic [RW-1:0]    i_addr,
    input  logic [REGNO-1:0] i_reg_ie,
    input  logic             i_mem_access,
    input  logic             i_mem_we,
    input  logic             i_mem_width,
    input  logic             i_data_page,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [RW-1:0]    o_mem_addr,
    output logic             o_mem_page,
    output logic [RW-1:0]    o_mem_data,
    output logic [1:0]       o_mem_sel,
    input  logic             i_mem_ack,
    input  logic [RW-1:0]    i_mem_data,
    output logic [REGNO-1:0] o_reg_ie,
    output logic [RW-1:0]    o_reg_data,
    output logic             o_fault
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MEM  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0]       state;
    logic [REGNO-1:0] reg_ie_q;   // destination of the pending load (0 for stores)
    logic             byte_q;     // pending access is a byte access
    logic             misaligned;
    logic [RW-1:0]    load_data;

    assign o_ready    = (state == S_IDLE);
    assign misaligned = !i_mem_width && i_addr[0];

    // Byte loads pick the lane addressed by addr[0] and zero-extend it.
    always_comb begin
        // NOTE: default first so every path assigns load_data and no latch is inferred.
        load_data = i_mem_data;
        if (byte_q) begin
            load_data = {{(RW-8){1'b0}}, (o_mem_addr[0] ? i_mem_data[15:8] : i_mem_data[7:0])};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            // NOTE: every register, including the captured bus fields, is reset so
            // the bus and register-file outputs are deterministic out of reset.
            state      <= S_IDLE;
            reg_ie_q   <= '0;
            byte_q     <= 1'b0;
            o_mem_req  <= 1'b0;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_page <= 1'b0;
            o_mem_data <= '0;
            o_mem_sel  <= 2'b00;
            o_reg_ie   <= '0;
            o_reg_data <= '0;
            o_fault    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; the pulse defaults below
            // are overridden later in the same block where a pulse is due.
            o_reg_ie <= '0;
            o_fault  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (i_submit) begin
                        if (!i_mem_access) begin
                            o_reg_ie   <= i_reg_ie;
                            o_reg_data <= i_data;
                        end else if (misaligned) begin
                            o_fault <= 1'b1;
                        end else begin
                            state      <= S_MEM;
                            o_mem_req  <= 1'b1;
                            o_mem_we   <= i_mem_we;
                            o_mem_addr <= i_addr;
                            o_mem_page <= i_data_page;
                            byte_q     <= i_mem_width;
                            // Stores never write the register file.
                            reg_ie_q   <= i_mem_we ? '0 : i_reg_ie;
                            if (i_mem_width) begin
                                o_mem_sel  <= i_addr[0] ? 2'b10 : 2'b01;
                                o_mem_data <= {(RW/8){i_data[7:0]}};
                            end else begin
                                o_mem_sel  <= 2'b11;
                                o_mem_data <= i_data;
                            end
                        end
                    end
                end

                S_MEM: begin
                    if (i_mem_ack) begin
                        o_mem_req <= 1'b0;
                        o_mem_we  <= 1'b0;
                        if (o_mem_we) begin
                            state <= S_IDLE;
                        end else begin
                            // Write-back is registered here so it lands during WB.
                            state      <= S_WB;
                            o_reg_ie   <= reg_ie_q;
                            o_reg_data <= load_data;
                        end
                    end
                end

                S_WB: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb.sv
// ---------------------------------------------------------------------------
// tb_mem_wb -- scoreboard bench for mem_wb
//
// The driver issues operations and pushes the expected bus request,
// write-back or fault into queues; independent monitors pop and compare
// whenever the DUT presents the corresponding output.
// ---------------------------------------------------------------------------
module tb_mem_wb;

    localparam int RW    = 16;
    localparam int REGNO = 8;

    logic             i_clk;
    logic             i_rst;
    logic             i_submit;
    logic             o_ready;
    logic [RW-1:0]    i_data;
    logic [RW-1:0]    i_addr;
    logic [REGNO-1:0] i_reg_ie;
    logic             i_mem_access;
    logic             i_mem_we;
    logic             i_mem_width;
    logic             i_data_page;
    logic             o_mem_req;
    logic             o_mem_we;
    logic [RW-1:0]    o_mem_addr;
    logic             o_mem_page;
    logic [RW-1:0]    o_mem_data;
    logic [1:0]       o_mem_sel;
    logic             i_mem_ack;
    logic [RW-1:0]    i_mem_data;
    logic [REGNO-1:0] o_reg_ie;
    logic [RW-1:0]    o_reg_data;
    logic             o_fault;

    mem_wb #(.RW(RW), .REGNO(REGNO)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_submit    (i_submit),
        .o_ready     (o_ready),
        .i_data      (i_data),
        .i_addr      (i_addr),
        .i_reg_ie    (i_reg_ie),
        .i_mem_access(i_mem_access),
        .i_mem_we    (i_mem_we),
        .i_mem_width (i_mem_width),
        .i_data_page (i_data_page),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_page  (o_mem_page),
        .o_mem_data  (o_mem_data),
        .o_mem_sel   (o_mem_sel),
        .i_mem_ack   (i_mem_ack),
        .i_mem_data  (i_mem_data),
        .o_reg_ie    (o_reg_ie),
        .o_reg_data  (o_reg_data),
        .o_fault     (o_fault)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [RW-1:0] addr;
        logic          page;
        logic          we;
        logic [RW-1:0] data;
        logic [1:0]    sel;
    } bus_t;

    bus_t                   bus_q[$];
    logic [REGNO+RW-1:0]    wb_q[$];
    int                     fault_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [REGNO-1:0] rand_ie();
        if ($urandom_range(0, 8) == 8) return '0;
        return REGNO'(1) << $urandom_range(0, REGNO-1);
    endfunction

    // ---------------- monitors ----------------
    logic prev_req = 1'b0;

    always @(negedge i_clk) begin
        if (o_reg_ie != '0) begin
            if (wb_q.size() == 0) begin
                check("unexpected_wb", 32'(o_reg_ie), 32'd0);
            end else begin
                logic [REGNO+RW-1:0] e;
                e = wb_q.pop_front();
                check("wb_reg_ie", 32'(o_reg_ie), 32'(e[REGNO+RW-1:RW]));
                check("wb_data", 32'(o_reg_data), 32'(e[RW-1:0]));
            end
        end
        if (o_fault) begin
            if (fault_q.size() == 0) check("unexpected_fault", 32'(o_fault), 32'd0);
            else begin
                void'(fault_q.pop_front());
                check("fault_pulse", 32'(o_fault), 32'd1);
            end
        end
        if (o_mem_req) begin
            if (bus_q.size() == 0) begin
                check("unexpected_req", 32'(o_mem_req), 32'd0);
            end else begin
                check("bus_addr", 32'(o_mem_addr), 32'(bus_q[0].addr));
                check("bus_page", 32'(o_mem_page), 32'(bus_q[0].page));
                check("bus_we",   32'(o_mem_we),   32'(bus_q[0].we));
                check("bus_data", 32'(o_mem_data), 32'(bus_q[0].data));
                check("bus_sel",  32'(o_mem_sel),  32'(bus_q[0].sel));
            end
        end else if (prev_req && bus_q.size() > 0) begin
            void'(bus_q.pop_front());
        end
        prev_req = o_mem_req;
    end

    // ---------------- driver tasks ----------------
    task automatic alu_op(input logic [REGNO-1:0] ie, input logic [RW-1:0] d, input logic spurious_ack);
        check("ready_before_alu", 32'(o_ready), 32'd1);
        i_submit     = 1'b1;
        i_mem_access = 1'b0;
        i_reg_ie     = ie;
        i_data       = d;
        i_addr       = RW'($urandom);
        i_mem_we     = 1'($urandom);
        i_mem_width  = 1'($urandom);
        i_mem_ack    = spurious_ack;
        i_mem_data   = RW'($urandom);
        if (ie != '0) wb_q.push_back({ie, d});
        step();
        i_submit  = 1'b0;
        i_mem_ack = 1'b0;
        check("no_req_after_alu", 32'(o_mem_req), 32'd0);
    endtask

    // we: 1 store; bw: 1 byte; lat: cycles between req and ack; rd: bus read data
    task automatic mem_op(input logic we, input logic bw, input logic [RW-1:0] addr,
                          input logic [RW-1:0] d, input logic [REGNO-1:0] ie,
                          input logic page, input int lat, input logic [RW-1:0] rd);
        bus_t b;
        logic [RW-1:0] exp_rd;
        check("ready_before_mem", 32'(o_ready), 32'd1);
        i_submit     = 1'b1;
        i_mem_access = 1'b1;
        i_mem_we     = we;
        i_mem_width  = bw;
        i_addr       = addr;
        i_data       = d;
        i_reg_ie     = ie;
        i_data_page  = page;
        if (!bw && addr[0]) begin
            fault_q.push_back(1);
            step();
            i_submit = 1'b0;
            check("fault_ready", 32'(o_ready), 32'd1);
            check("fault_no_req", 32'(o_mem_req), 32'd0);
            step();
            check("fault_ready2", 32'(o_ready), 32'd1);
            return;
        end
        b.addr = addr;
        b.page = page;
        b.we   = we;
        b.sel  = bw ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
        b.data = bw ? {d[7:0], d[7:0]} : d;
        bus_q.push_back(b);
        step();
        // Junk submits while stalled must be ignored.
        i_submit     = 1'($urandom);
        i_mem_access = 1'($urandom);
        i_data       = RW'($urandom);
        i_addr       = RW'($urandom);
        i_reg_ie     = rand_ie();
        check("req_first", 32'(o_mem_req), 32'd1);
        check("ready_mem", 32'(o_ready), 32'd0);
        for (int i = 0; i < lat; i++) begin
            step();
            check("req_held", 32'(o_mem_req), 32'd1);
            check("ready_held", 32'(o_ready), 32'd0);
        end
        i_mem_ack  = 1'b1;
        i_mem_data = rd;
        if (!we) begin
            exp_rd = bw ? {8'h00, (addr[0] ? rd[15:8] : rd[7:0])} : rd;
            if (ie != '0) wb_q.push_back({ie, exp_rd});
        end
        step();
        i_mem_ack = 1'b0;
        i_submit  = 1'b0;
        check("req_drop", 32'(o_mem_req), 32'd0);
        if (!we) begin
            check("ready_wb", 32'(o_ready), 32'd0);
            step();
        end
        check("ready_after", 32'(o_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        i_rst = 1'b0;
        i_submit = 1'b0; i_data = '0; i_addr = '0; i_reg_ie = '0;
        i_mem_access = 1'b0; i_mem_we = 1'b0; i_mem_width = 1'b0; i_data_page = 1'b0;
        i_mem_ack = 1'b0; i_mem_data = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_req", 32'(o_mem_req), 32'd0);
        check("rst_reg_ie", 32'(o_reg_ie), 32'd0);
        check("rst_fault", 32'(o_fault), 32'd0);
        check("rst_sel", 32'(o_mem_sel), 32'd0);
        check("rst_addr", 32'(o_mem_addr), 32'd0);
        check("rst_reg_data", 32'(o_reg_data), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b1;
        step();

        // Back-to-back ALU write-backs.
        alu_op(8'h04, 16'h1234, 1'b0);
        alu_op(8'h01, 16'h0005, 1'b0);
        step();
        // Word load, ack three cycles after req.
        mem_op(1'b0, 1'b0, 16'h0100, 16'h0000, 8'h02, 1'b0, 3, 16'hBEEF);
        // Byte load, odd address, same-cycle ack.
        mem_op(1'b0, 1'b1, 16'h0101, 16'h0000, 8'h08, 1'b1, 0, 16'hA55A);
        // Byte store, reg_ie must be suppressed.
        mem_op(1'b1, 1'b1, 16'h0200, 16'h00C3, 8'h10, 1'b0, 1, 16'hFFFF);
        // Misaligned word store.
        mem_op(1'b1, 1'b0, 16'h0003, 16'h1111, 8'h20, 1'b0, 0, 16'h0000);

        // Reset while a load is pending, then a spurious ack.
        begin
            bus_t b;
            b.addr = 16'h0400; b.page = 1'b0; b.we = 1'b0; b.data = 16'h7777; b.sel = 2'b11;
            bus_q.push_back(b);
            i_submit = 1'b1; i_mem_access = 1'b1; i_mem_we = 1'b0; i_mem_width = 1'b0;
            i_addr = 16'h0400; i_data = 16'h7777; i_reg_ie = 8'h40; i_data_page = 1'b0;
            step();
            i_submit = 1'b0;
            check("rst_mid_req", 32'(o_mem_req), 32'd1);
            i_rst = 1'b0;
            #1;
            check("rst_mid_req_drop", 32'(o_mem_req), 32'd0);
            check("rst_mid_ready", 32'(o_ready), 32'd1);
            bus_q.delete();
            @(negedge i_clk);
            #3;
            i_rst = 1'b1;
            step();
            i_mem_ack = 1'b1; i_mem_data = 16'h5555;
            step();
            i_mem_ack = 1'b0;
            check("spur_ack_req", 32'(o_mem_req), 32'd0);
            check("spur_ack_ready", 32'(o_ready), 32'd1);
            check("spur_ack_wb", 32'(o_reg_ie), 32'd0);
            step();
            check("spur_ack_wb2", 32'(o_reg_ie), 32'd0);
        end

        // Randomized mix.
        for (int n = 0; n < 300; n++) begin
            int kind;
            kind = $urandom_range(0, 3);
            if (kind < 2) begin
                alu_op(rand_ie(), RW'($urandom), 1'($urandom_range(0, 3) == 0));
            end else begin
                logic [RW-1:0] a;
                a = RW'($urandom);
                if ($urandom_range(0, 3) != 0) a[0] = a[0] & 1'($urandom);
                mem_op(1'($urandom), 1'($urandom), a, RW'($urandom), rand_ie(),
                       1'($urandom), $urandom_range(0, 3), RW'($urandom));
            end
            if ($urandom_range(0, 4) == 0) step();
        end

        repeat (3) step();
        check("wb_q_drained", 32'(wb_q.size()), 32'd0);
        check("fault_q_drained", 32'(fault_q.size()), 32'd0);
        check("bus_q_drained", 32'(bus_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb.md
Name: mem_wb

Overview:
- Memory/write-back pipeline stage; consumer end of the execute-stage forwarding handshake (`o_submit`/`i_next_ready`, data/addr/reg_ie/mem controls).
- Performs the data-bus load/store requested by execute and returns write-back data and register enables to the register file.
- Non-memory results pass through at one per cycle. Memory operations stall the upstream stage by deasserting `o_ready` until the data-bus acknowledge.

Parameters:
- RW, 16, data/address word width
- REGNO, 8, number of registers (one-hot write-enable width)

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  asynchronous active-low reset (asserted at 0)
- i_submit  input  1  execute result valid this cycle
- o_ready  output  1  stage can accept; drives execute `i_next_ready`
- i_data  input  RW  ALU result, or store data when `i_mem_access`
- i_addr  input  RW  byte address for memory access
- i_reg_ie  input  REGNO  one-hot destination register enable (0 = none)
- i_mem_access  input  1  operation is load/store
- i_mem_we  input  1  1 = store, 0 = load
- i_mem_width  input  1  1 = byte, 0 = word
- i_data_page  input  1  data page select, sampled with submit
- o_mem_req  output  1  data-bus request
- o_mem_we  output  1  data-bus write
- o_mem_addr  output  RW  data-bus byte address
- o_mem_page  output  1  data-bus page bit
- o_mem_data  output  RW  store data
- o_mem_sel  output  2  byte lane select ([0] low byte, [1] high byte)
- i_mem_ack  input  1  data-bus acknowledge, one cycle
- i_mem_data  input  RW  read data, valid with `i_mem_ack`
- o_reg_ie  output  REGNO  register-file write enable, one-cycle pulse
- o_reg_data  output  RW  register-file write data
- o_fault  output  1  misaligned word access, one-cycle pulse

Behaviour:
- Reset (`i_rst`=0, async): state IDLE; `o_mem_req`, `o_mem_we`, `o_reg_ie`, `o_fault`, `o_mem_sel` = 0; `o_mem_addr`/`o_mem_data`/`o_reg_data`/`o_mem_page` = 0. Reset mid-access drops `o_mem_req` immediately; no write-back occurs.
- States: IDLE, MEM, WB.
- `o_ready` = (state==IDLE), combinational from state only.
- `i_submit` while `o_ready`=0 is ignored; no capture.
- IDLE, `i_submit`=1 and `i_mem_access`=0: next cycle `o_reg_ie`=`i_reg_ie` and `o_reg_data`=`i_data` for exactly one cycle; stay IDLE. Back-to-back submits give one write-back per cycle.
- IDLE, `i_submit`=1 and `i_mem_access`=1 and word access with `i_addr[0]`=1:
  - next cycle `o_fault`=1 for one cycle; no bus cycle, `o_reg_ie`=0; stay IDLE.
- IDLE, `i_submit`=1 and `i_mem_access`=1 (aligned, or byte): capture all fields; go to MEM.
- MEM: `o_mem_req`=1 registered, asserted the cycle after submit. `o_mem_addr`, `o_mem_page`, `o_mem_we`, `o_mem_data`, `o_mem_sel` are held stable until ack.
- Lane rules:
  - word: `o_mem_sel`=2'b11, `o_mem_data`=data.
  - byte: `o_mem_sel` = `addr[0]` ? 2'b10 : 2'b01, `o_mem_data`={data[7:0],data[7:0]}.
- `i_mem_ack` is accepted only in MEM; it may arrive in the first MEM cycle. An ack outside MEM is ignored.
- Ack in MEM: `o_mem_req` deasserts the next cycle. Load goes to WB; store goes to IDLE with no write-back.
- Load formatting, registered at ack:
  - word: `o_reg_data`=`i_mem_data`.
  - byte: `o_reg_data` = zero-extended `addr[0]` ? `i_mem_data[15:8]` : `i_mem_data[7:0]`.
- WB: `o_reg_ie`=captured reg_ie for one cycle; next state IDLE.
  - `o_ready` is 0 during WB and 1 the cycle after, so execute sees the hazard cleared after the write lands.
- Store write-back is forced to `o_reg_ie`=0 regardless of `i_reg_ie`.
- Load latency with same-cycle ack: submit N, req N+1, ack N+1, write-back N+2, ready N+3.
- `o_reg_ie` is 0 in every cycle not listed above.

Test Plan:
- Reset released, submit ALU op data=16'h1234, reg_ie=8'h04, then next-cycle op data=16'h0005, reg_ie=8'h01 -> write-backs 8'h04/1234 then 8'h01/0005 on consecutive cycles; `o_ready` stays 1; `o_mem_req` stays 0.
- Word load addr=16'h0100, ack 3 cycles after req with `i_mem_data`=16'hBEEF, reg_ie=8'h02 -> req held 3 cycles with sel=11, `o_ready` 0 throughout; then write-back 8'h02/BEEF for one cycle; then `o_ready`=1.
- Byte load addr=16'h0101, ack in same cycle as req with `i_mem_data`=16'hA55A -> sel=10; `o_reg_data`=16'h00A5 the following cycle.
- Byte store data=16'h00C3 addr=16'h0200 with reg_ie=8'h10 -> `o_mem_data`=16'hC3C3, sel=01, we=1; `o_reg_ie` never nonzero; `o_ready` returns the cycle after ack.
- Word store addr=16'h0003 -> `o_fault` pulse next cycle; `o_mem_req` never asserted; `o_ready` stays 1.
- Reset asserted while req pending, then spurious `i_mem_ack` after release -> `o_mem_req` 0 immediately; no write-back; state IDLE; ack ignored.
